// File: rtl/zet_prefetch_q_if.sv
// Signal bundle for the prefetch queue: the fetch-unit side (pc/fetch/flush/data/block)
// and the memory bus side (m_*). The prefetch queue itself takes the master modport.
interface zet_prefetch_q_if;
    logic [19:0] pc;
    logic        bytefetch;
    logic        fetch_req;
    logic        flush;
    logic [15:0] data;
    logic        block;
    logic [18:0] m_adr;
    logic        m_cyc;
    logic        m_stb;
    logic [1:0]  m_sel;
    logic        m_ack;
    logic [15:0] m_dat_i;

    modport master (
        input  pc, bytefetch, fetch_req, flush, m_ack, m_dat_i,
        output data, block, m_adr, m_cyc, m_stb, m_sel
    );

    modport slave (
        output pc, bytefetch, fetch_req, flush, m_ack, m_dat_i,
        input  data, block, m_adr, m_cyc, m_stb, m_sel
    );
endinterface

// File: rtl/zet_prefetch_q.sv
// Six-byte instruction prefetch queue: fills from a 16-bit bus one word at a time and
// hands one or two head bytes per cycle to the fetch unit.
module zet_prefetch_q (
    input  logic             clk,
    input  logic             rst,
    zet_prefetch_q_if.master bus
);
    typedef enum logic {IDLE, READ} state_t;

    state_t      state_q, state_d;
    logic        drop_q, drop_d;
    logic [2:0]  count_q, count_d;
    logic [2:0]  head_q, head_d;
    logic [2:0]  tail_q, tail_d;
    logic [19:0] qaddr_q, qaddr_d;
    logic [7:0]  queue_q [6];
    logic [7:0]  queue_d [6];
    logic        m_cyc_q, m_cyc_d;
    logic [18:0] m_adr_q, m_adr_d;
    logic [1:0]  m_sel_q, m_sel_d;

    logic        block;
    logic [1:0]  pop_n;
    logic [1:0]  push_n;
    logic [3:0]  count_sum;
    logic [2:0]  head_p1;

    function automatic logic [2:0] ptr_add(input logic [2:0] p, input logic [1:0] n);
        logic [3:0] s;
        s = {1'b0, p} + {2'b00, n};
        return (s >= 4'd6) ? 3'(s - 4'd6) : s[2:0];
    endfunction

    assign head_p1   = ptr_add(head_q, 2'd1);
    assign block     = bus.flush | (bus.bytefetch ? (count_q < 3'd1) : (count_q < 3'd2));
    assign bus.block = block;
    assign bus.data  = {(count_q >= 3'd2) ? queue_q[head_p1] : 8'h00,
                        (count_q >= 3'd1) ? queue_q[head_q]  : 8'h00};
    assign bus.m_cyc = m_cyc_q;
    assign bus.m_stb = m_cyc_q;
    assign bus.m_adr = m_adr_q;
    assign bus.m_sel = m_sel_q;

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        head_d  = head_q;
        tail_d  = tail_q;
        qaddr_d = qaddr_q;
        queue_d = queue_q;
        m_cyc_d = m_cyc_q;
        m_adr_d = m_adr_q;
        m_sel_d = m_sel_q;
        push_n  = 2'd0;
        // block already includes flush, so a flush cycle never pops
        pop_n   = (bus.fetch_req & ~block) ? (bus.bytefetch ? 2'd1 : 2'd2) : 2'd0;

        // m_cyc may stay high in IDLE while a flushed read drains (drop_q = 1)
        if (m_cyc_q && bus.m_ack) begin
            m_cyc_d = 1'b0;
            m_sel_d = 2'b00;
            drop_d  = 1'b0;
            state_d = IDLE;
            if (state_q == READ && !bus.flush) begin
                if (qaddr_q[0]) begin
                    queue_d[tail_q] = bus.m_dat_i[15:8];
                    push_n          = 2'd1;
                    qaddr_d         = qaddr_q + 20'd1;
                end else begin
                    queue_d[tail_q]                = bus.m_dat_i[7:0];
                    queue_d[ptr_add(tail_q, 2'd1)] = bus.m_dat_i[15:8];
                    push_n                         = 2'd2;
                    qaddr_d                        = qaddr_q + 20'd2;
                end
            end
        end else if (state_q == READ) begin
            if (bus.flush) begin
                state_d = IDLE;
                drop_d  = 1'b1;
            end
        end else if (!bus.flush && !drop_q && count_q <= 3'd4) begin
            state_d = READ;
            m_cyc_d = 1'b1;
            m_sel_d = 2'b11;
            m_adr_d = qaddr_q[19:1];
        end

        count_sum = {1'b0, count_q} + {2'b00, push_n} - {2'b00, pop_n};
        count_d   = count_sum[2:0];
        head_d    = ptr_add(head_q, pop_n);
        tail_d    = ptr_add(tail_q, push_n);

        if (bus.flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            qaddr_d = bus.pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            qaddr_q <= 20'hFFFF0;
            m_cyc_q <= 1'b0;
            m_adr_q <= '0;
            m_sel_q <= '0;
        end else begin
            assert (count_sum <= 4'd6);
            state_q <= state_d;
            drop_q  <= drop_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            qaddr_q <= qaddr_d;
            m_cyc_q <= m_cyc_d;
            m_adr_q <= m_adr_d;
            m_sel_q <= m_sel_d;
        end
        queue_q <= queue_d;
    end
endmodule

// File: tb/tb_zet_prefetch_q.sv
// Bench for zet_prefetch_q: directed scenarios then random traffic, all outputs compared
// against a byte-queue reference model held in the bench.
module tb_zet_prefetch_q;
    logic clk = 1'b0;
    logic rst;

    zet_prefetch_q_if bus ();

    zet_prefetch_q dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: queue of bytes, fill address, bus cycle flags
    logic [7:0]  mq [$];
    logic [19:0] m_qaddr  = 20'hFFFF0;
    logic        m_cyc_e  = 1'b0;
    logic        m_drop   = 1'b0;
    logic [18:0] m_adr_e  = '0;
    bit          model_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int sz;
        logic [15:0] d_exp;
        logic blk_exp;
        sz = mq.size();
        blk_exp = bus.flush || (bus.bytefetch ? (sz < 1) : (sz < 2));
        d_exp = 16'h0000;
        if (sz >= 1) d_exp[7:0]  = mq[0];
        if (sz >= 2) d_exp[15:8] = mq[1];
        chk("block", {31'b0, bus.block}, {31'b0, blk_exp});
        chk("data", {16'b0, bus.data}, {16'b0, d_exp});
        chk("m_cyc", {31'b0, bus.m_cyc}, {31'b0, m_cyc_e});
        chk("m_stb", {31'b0, bus.m_stb}, {31'b0, m_cyc_e});
        if (m_cyc_e) begin
            chk("m_adr", {13'b0, bus.m_adr}, {13'b0, m_adr_e});
            chk("m_sel", {30'b0, bus.m_sel}, 32'd3);
        end
    endtask

    task automatic model_edge();
        int sz;
        logic blk;
        if (rst) begin
            mq.delete();
            m_qaddr  = 20'hFFFF0;
            m_cyc_e  = 1'b0;
            m_drop   = 1'b0;
            model_on = 1'b1;
            return;
        end
        sz  = mq.size();
        blk = bus.flush || (bus.bytefetch ? (sz < 1) : (sz < 2));
        if (bus.flush) begin
            mq.delete();
            if (m_cyc_e && !bus.m_ack) m_drop = 1'b1;
            else if (m_cyc_e) begin
                m_cyc_e = 1'b0;
                m_drop  = 1'b0;
            end
            m_qaddr = bus.pc;
            return;
        end
        if (bus.fetch_req && !blk)
            repeat (bus.bytefetch ? 1 : 2) void'(mq.pop_front());
        if (m_cyc_e && bus.m_ack) begin
            if (!m_drop) begin
                if (m_qaddr[0]) begin
                    mq.push_back(bus.m_dat_i[15:8]);
                    m_qaddr = m_qaddr + 20'd1;
                end else begin
                    mq.push_back(bus.m_dat_i[7:0]);
                    mq.push_back(bus.m_dat_i[15:8]);
                    m_qaddr = m_qaddr + 20'd2;
                end
            end
            m_cyc_e = 1'b0;
            m_drop  = 1'b0;
        end else if (!m_cyc_e && (6 - sz) >= 2) begin
            m_cyc_e = 1'b1;
            m_adr_e = m_qaddr[19:1];
        end
    endtask

    task automatic step();
        #1;
        if (model_on) check_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic wait_read();
        int n;
        n = 0;
        while (!(m_cyc_e && !m_drop) && n < 8) begin
            step();
            n++;
        end
        #1 chk("wait_read", {31'b0, bus.m_cyc}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.pc = '0;
        bus.bytefetch = 1'b0;
        bus.fetch_req = 1'b0;
        bus.flush = 1'b0;
        bus.m_ack = 1'b0;
        bus.m_dat_i = '0;
        step();
        step();
        #1;
        chk("rst_m_cyc", {31'b0, bus.m_cyc}, 32'd0);
        chk("rst_m_stb", {31'b0, bus.m_stb}, 32'd0);
        chk("rst_m_adr", {13'b0, bus.m_adr}, 32'd0);
        chk("rst_m_sel", {30'b0, bus.m_sel}, 32'd0);
        chk("rst_block", {31'b0, bus.block}, 32'd1);
        chk("rst_data", {16'b0, bus.data}, 32'd0);

        // reset fill
        rst = 1'b0;
        step();
        #1 chk("fill_adr", {13'b0, bus.m_adr}, 32'h7FFF8);
        chk("fill_sel", {30'b0, bus.m_sel}, 32'd3);
        bus.m_ack = 1'b1; bus.m_dat_i = 16'hEA90;
        step();
        bus.m_ack = 1'b0;
        #1 chk("fill_data", {16'b0, bus.data}, 32'hEA90);
        chk("fill_block", {31'b0, bus.block}, 32'd0);

        // odd flush address
        bus.flush = 1'b1; bus.pc = 20'h00101;
        step();
        bus.flush = 1'b0;
        step();
        #1 chk("odd_adr", {13'b0, bus.m_adr}, 32'h00080);
        bus.m_ack = 1'b1; bus.m_dat_i = 16'h3412;
        step();
        bus.m_ack = 1'b0;
        #1 chk("odd_data", {16'b0, bus.data}, 32'h0034);
        chk("odd_block2", {31'b0, bus.block}, 32'd1);
        bus.bytefetch = 1'b1;
        #1 chk("odd_block1", {31'b0, bus.block}, 32'd0);
        bus.bytefetch = 1'b0;
        step();
        #1 chk("odd_next_adr", {13'b0, bus.m_adr}, 32'h00081);

        // full queue
        bus.flush = 1'b1; bus.pc = 20'h00200;
        step();
        bus.flush = 1'b0;
        bus.m_ack = 1'b1; bus.m_dat_i = 16'($urandom);
        step();
        bus.m_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_read();
            bus.m_ack = 1'b1; bus.m_dat_i = 16'($urandom);
            step();
            bus.m_ack = 1'b0;
        end
        step();
        #1 chk("full_idle0", {31'b0, bus.m_cyc}, 32'd0);
        step();
        #1 chk("full_idle1", {31'b0, bus.m_cyc}, 32'd0);
        chk("full_block", {31'b0, bus.block}, 32'd0);
        bus.fetch_req = 1'b1;
        step();
        bus.fetch_req = 1'b0;
        step();
        #1 chk("full_reissue", {31'b0, bus.m_cyc}, 32'd1);

        // flush while a read is in flight
        bus.flush = 1'b1; bus.pc = 20'h01000;
        step();
        bus.flush = 1'b0;
        step();
        #1 chk("drop_hold", {31'b0, bus.m_cyc}, 32'd1);
        step();
        bus.m_ack = 1'b1; bus.m_dat_i = 16'hFFFF;
        step();
        bus.m_ack = 1'b0;
        #1 chk("drop_data", {16'b0, bus.data}, 32'h0000);
        chk("drop_block", {31'b0, bus.block}, 32'd1);
        chk("drop_cyc", {31'b0, bus.m_cyc}, 32'd0);
        step();
        #1 chk("drop_adr", {13'b0, bus.m_adr}, 32'h00800);

        // push and pop in the same cycle
        bus.m_ack = 1'b1; bus.m_dat_i = 16'h1234;
        step();
        bus.m_ack = 1'b0;
        step();
        bus.m_ack = 1'b1; bus.m_dat_i = 16'h5678; bus.fetch_req = 1'b1;
        step();
        bus.m_ack = 1'b0; bus.fetch_req = 1'b0;
        #1 chk("pp_data", {16'b0, bus.data}, 32'h5678);
        chk("pp_block", {31'b0, bus.block}, 32'd0);

        // fill address wrap
        bus.flush = 1'b1; bus.pc = 20'hFFFFE;
        step();
        bus.flush = 1'b0;
        step();
        #1 chk("wrap_adr0", {13'b0, bus.m_adr}, 32'h7FFFF);
        bus.m_ack = 1'b1; bus.m_dat_i = 16'hBEEF;
        step();
        bus.m_ack = 1'b0;
        step();
        #1 chk("wrap_adr1", {13'b0, bus.m_adr}, 32'h00000);

        // reset mid-cycle, then a stray ack
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1 chk("rst_mid_cyc", {31'b0, bus.m_cyc}, 32'd0);
        bus.m_ack = 1'b1; bus.m_dat_i = 16'hAAAA;
        step();
        bus.m_ack = 1'b0;
        #1 chk("stray_data", {16'b0, bus.data}, 32'h0000);
        chk("stray_adr", {13'b0, bus.m_adr}, 32'h7FFF8);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            rst           = ($urandom_range(0, 299) == 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            bus.pc        = ($urandom_range(0, 3) == 0) ? 20'hFFFFF - 20'($urandom_range(0, 3))
                                                        : 20'($urandom);
            bus.fetch_req = 1'($urandom_range(0, 1));
            bus.bytefetch = 1'($urandom_range(0, 1));
            bus.m_ack     = ($urandom_range(0, 9) < 4);
            bus.m_dat_i   = 16'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/zet_prefetch_q.md
ZET_PREFETCH_Q -- requirements
Module: zet_prefetch_q

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 pc  in  20  linear byte address the fetch unit reads next; sampled only on flush.
REQ-004 bytefetch  in  1  1 = consume one byte, 0 = consume two bytes.
REQ-005 fetch_req  in  1  fetch unit consumes head bytes this cycle.
REQ-006 flush  in  1  control transfer; discard queue, refill from pc.
REQ-007 data  out  16  {head+1 byte, head byte} to fetch unit.
REQ-008 block  out  1  requested byte count not available; fetch unit stalls.
REQ-009 m_adr  out  19  memory word address (byte address >> 1).
REQ-010 m_cyc, m_stb  out  1 each  bus cycle active, asserted together.
REQ-011 m_sel  out  2  byte lanes, always 2'b11 during a cycle.
REQ-012 m_ack  in  1  memory read complete, data valid on m_dat_i.
REQ-013 m_dat_i  in  16  read word, low byte = even address.

Function
REQ-014 The block SHALL be a 6-byte circular byte queue with head/tail pointers wrapping 5->0 and count 0..6.
REQ-015 The block SHALL keep a 20-bit fill address qaddr, the byte address of the next byte to enqueue, wrapping 20'hFFFFF -> 20'h00000.
REQ-016 The block SHALL use FSM states IDLE and READ.
- IDLE -> READ when !flush and (6 - count) >= 2.
- READ -> IDLE on m_ack or flush.
REQ-017 In READ, m_cyc = m_stb = 1, m_adr = qaddr[19:1], m_sel = 2'b11, all held stable until m_ack; in IDLE m_cyc = m_stb = 0.
REQ-018 On m_ack without drop and without flush:
- qaddr[0] = 0: enqueue m_dat_i[7:0] then m_dat_i[15:8], qaddr += 2.
- qaddr[0] = 1: enqueue m_dat_i[15:8] only, qaddr += 1.
REQ-019 Enqueued bytes SHALL be visible on data the cycle after m_ack; there is no bypass.
REQ-020 block = bytefetch ? (count < 1) : (count < 2); block SHALL also be 1 in any cycle flush = 1.
REQ-021 data[7:0] = queue[head] if count >= 1, else 8'h00; data[15:8] = queue[head+1] if count >= 2, else 8'h00.
REQ-022 On fetch_req & !block & !flush, head SHALL advance by 1 (bytefetch = 1) or 2 (bytefetch = 0).
REQ-023 Enqueue and dequeue in the same cycle SHALL combine: count_next = count + pushed - popped.
REQ-024 On flush:
- count, head, and tail SHALL be cleared and qaddr loaded with pc.
- Any fetch_req that cycle SHALL be ignored.
REQ-025 Flush in READ without m_ack:
- FSM SHALL go IDLE and set drop.
- m_cyc/m_stb SHALL be held until m_ack, then drop is cleared.
- The acked data SHALL be discarded and qaddr left unchanged.
- No new cycle SHALL issue while drop = 1.
REQ-026 Flush coinciding with m_ack SHALL discard the acked data; drop is not set.
REQ-027 A new read SHALL start no earlier than the cycle after flush.
REQ-028 Space is checked at issue and count only falls while a cycle is in flight, so the queue SHALL never overflow; an overflow is a design error flagged by an assertion.

Reset
REQ-029 On rst = 1 at a clock edge, reset state SHALL be:
- state = IDLE, count = 0, head = tail = 0, drop = 0.
- qaddr = 20'hFFFF0.
- m_cyc = m_stb = 0, m_adr = 19'h0, m_sel = 2'b00.
- block = 1, data = 16'h0000.
REQ-030 Reset mid-bus-cycle SHALL drop m_cyc/m_stb the next cycle; a later stray m_ack SHALL be ignored.

Verification
REQ-031 Reset fill: release rst -> next cycle m_adr = 19'h7FFF8, m_sel = 2'b11; ack 16'hEA90 -> following cycle data = 16'hEA90, count = 2, block = 0 for bytefetch = 0.
REQ-032 Odd flush: flush pc = 20'h00101 -> m_adr = 19'h00080; ack 16'h3412 -> count = 1, data = 16'h0034, block = 1 if bytefetch = 0, block = 0 if bytefetch = 1, next m_adr = 19'h00081.
REQ-033 Full queue: no fetch_req, ack three words -> count = 6, m_cyc stays 0; one 2-byte pop -> a new read issues the next cycle.
REQ-034 Flush in flight: flush pc = 20'h01000 while READ, ack 3 cycles later with 16'hFFFF -> nothing enqueued, count = 0; then m_adr = 19'h00800.
REQ-035 Simultaneous push/pop: count = 2, m_ack with 16'h5678 and 2-byte pop the same cycle -> count = 2, data = 16'h5678.
REQ-036 Wrap: flush pc = 20'hFFFFE, ack -> qaddr = 20'h00000, next m_adr = 19'h00000.
